// File: rtl/fxp_sqrt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fxp_sqrt_pkg
// Purpose  : Shared fixed-point constants for the normalisation path. FXP_N
//            and FXP_R are the same word/fraction sizes the divider uses, so
//            the root produced here drops straight into the divider b input.
// Contents : FXP_N, FXP_R  - default total / fractional bits
//            fxp_even_up() - round a bit count up to the next even value
// Revision : 1.0 - initial release
// ============================================================================
package fxp_sqrt_pkg;

  localparam int FXP_N = 16;
  localparam int FXP_R = 8;

  // The radicand is consumed two bits per iteration, so its register
  // width must be even.
  function automatic int fxp_even_up(input int n);
    return n + (n % 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fxp_sqrt_if.sv
`default_nettype none
// ============================================================================
// Module   : fxp_sqrt_if
// Purpose  : Request/result bundle for the fixed-point square root.
// Signals  : start - request a root of a (requester -> root unit)
//            a     - signed radicand, Q(WIDTH-FBITS).FBITS
//            busy  - computation in progress
//            done  - single-cycle pulse in the final cycle of a computation
//            valid - val holds a completed result
//            neg   - start rejected because a was negative
//            val   - signed result, same Q format, always >= 0
// Modports : master (requester), slave (root unit)
// Revision : 1.0 - initial release
// ============================================================================
interface fxp_sqrt_if #(
  parameter int WIDTH = 16
);
  logic                    start;
  logic signed [WIDTH-1:0] a;
  logic                    busy;
  logic                    done;
  logic                    valid;
  logic                    neg;
  logic signed [WIDTH-1:0] val;

  modport master (
    output start, a,
    input  busy, done, valid, neg, val
  );

  modport slave (
    input  start, a,
    output busy, done, valid, neg, val
  );
endinterface
`default_nettype wire

// File: rtl/fxp_sqrt.sv
`default_nettype none
// ============================================================================
// Module   : fxp_sqrt
// Purpose  : Iterative signed fixed-point square root, one root bit per
//            cycle (digit-by-digit restoring), rounded to nearest. Feeds the
//            fixed-point divider as its b operand.
// Ports    : clk  - clock, rising edge
//            rst  - reset, asynchronous, active-high
//            bus  - fxp_sqrt_if.slave (start, a, busy, done, valid, neg, val)
// Latency  : ITER+2 cycles from accepted start to valid (14 for 16/8).
// Revision : 1.0 - initial release
// ============================================================================
module fxp_sqrt
  import fxp_sqrt_pkg::*;
#(
  parameter int WIDTH = FXP_N,
  parameter int FBITS = FXP_R
) (
  input  wire logic  clk,
  input  wire logic  rst,
  fxp_sqrt_if.slave  bus
);

  // Radicand is a << FBITS so the root lands back in the same Q format.
  localparam int c_RW   = fxp_even_up(WIDTH + FBITS);
  localparam int c_ITER = c_RW / 2;
  localparam int c_RMW  = c_ITER + 2;
  localparam int c_CW   = (c_ITER > 1) ? $clog2(c_ITER) : 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_INIT  = 2'd1;
  localparam logic [1:0] c_CALC  = 2'd2;
  localparam logic [1:0] c_ROUND = 2'd3;

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [c_RW-1:0]        r_rad;
  logic [c_RMW-1:0]       r_rem;
  logic [c_ITER-1:0]      r_root;
  logic [c_CW-1:0]        r_count;
  logic                   r_busy;
  logic                   r_valid;
  logic                   r_neg;
  logic [WIDTH-1:0]       r_val;

  logic [c_RW-1:0]        w_a_ext;
  logic [c_RMW-1:0]       w_rem_sh;
  logic [c_RMW-1:0]       w_trial;
  logic                   w_fits;
  logic [c_RMW-1:0]       w_rem_nxt;
  logic [c_ITER-1:0]      w_root_nxt;
  logic                   w_round_up;
  logic [c_ITER-1:0]      w_root_rnd;
  logic                   w_accept;
  logic                   w_last_iter;

  // ---------------------------------------------------------------------------
  // Datapath: one restoring step per CALC cycle
  // ---------------------------------------------------------------------------
  assign w_a_ext = c_RW'($unsigned(bus.a));

  // The two remainder MSBs dropped here are always zero: the remainder never
  // exceeds 2*root, which fits in ITER+1 bits before the shift.
  assign w_rem_sh   = {r_rem[c_RMW-3:0], r_rad[c_RW-1 -: 2]};
  assign w_trial    = {r_root, 2'b01};
  assign w_fits     = (w_rem_sh >= w_trial);
  assign w_rem_nxt  = w_fits ? (w_rem_sh - w_trial) : w_rem_sh;
  assign w_root_nxt = {r_root[c_ITER-2:0], w_fits};

  // Final remainder r = x - q^2; sqrt(x) >= q + 0.5 exactly when r > q.
  // An exact half cannot occur for integer x, so this is round-half-up.
  assign w_round_up = (r_rem > {2'b00, r_root});
  assign w_root_rnd = r_root + c_ITER'(w_round_up);

  assign w_accept    = bus.start && (r_state == c_IDLE) && !r_neg;
  assign w_last_iter = (r_count == c_CW'(c_ITER - 1));

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_accept && !bus.a[WIDTH-1]) w_state_nxt = c_INIT;
      c_INIT:  w_state_nxt = c_CALC;
      c_CALC:  if (w_last_iter) w_state_nxt = c_ROUND;
      c_ROUND: w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_rad   <= '0;
      r_rem   <= '0;
      r_root  <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_neg   <= 1'b0;
      r_val   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            if (bus.a[WIDTH-1]) begin
              // Rejected: flag for one cycle, old val stays on the bus.
              r_neg   <= 1'b1;
              r_valid <= 1'b0;
            end else begin
              r_busy  <= 1'b1;
              r_valid <= 1'b0;
              r_neg   <= 1'b0;
              r_rad   <= w_a_ext << FBITS;
            end
          end else begin
            r_neg <= 1'b0;
          end
        end
        c_INIT: begin
          r_rem   <= '0;
          r_root  <= '0;
          r_count <= '0;
        end
        c_CALC: begin
          r_rem   <= w_rem_nxt;
          r_root  <= w_root_nxt;
          r_rad   <= r_rad << 2;
          r_count <= r_count + 1'b1;
        end
        c_ROUND: begin
          // Radicand <= 2^(WIDTH-1)-1 keeps the rounded root below the sign
          // bit, so no saturation is needed.
          r_root  <= w_root_rnd;
          r_val   <= WIDTH'(w_root_rnd);
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.valid = r_valid;
  assign bus.neg   = r_neg;
  assign bus.val   = r_val;
  assign bus.done  = (r_state != w_state_nxt) && (w_state_nxt == c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fxp_sqrt.sv
`default_nettype none
// ============================================================================
// Module   : tb_fxp_sqrt
// Purpose  : Self-checking bench for fxp_sqrt (16/8 configuration).
//            Expected roots come from an integer model of
//            floor(sqrt(a*256) + 0.5) and are queued at request time,
//            then compared when the unit finishes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fxp_sqrt;

  localparam int WIDTH = 16;
  localparam int FBITS = 8;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  logic [15:0] sb[$];
  bit          pending = 0;

  fxp_sqrt_if #(.WIDTH(WIDTH)) sq_if ();

  fxp_sqrt #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] av);
    longint x;
    longint r;
    x = longint'(av) * 256;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    if (x - r * r > r) r++;
    return r[15:0];
  endfunction

  // Result monitor: the edge after a done pulse must deliver the queued value.
  always @(negedge clk) begin
    if (pending) begin
      pending = 0;
      if (sb.size() == 0) begin
        check_val("unexpected_result", int'(sq_if.val), -1);
      end else begin
        check_val("result_val", int'(sq_if.val), int'(sb.pop_front()));
        check_val("result_valid", int'(sq_if.valid), 1);
      end
    end
    if (sq_if.done) pending = 1;
  end

  // One request with latency/busy/done timing checks; optional re-pulse of
  // start while busy with a different operand that must be ignored.
  task automatic run_one(input logic [15:0] av, input bit repulse,
                         input logic [15:0] rp_a);
    int n, lat, dn, bcnt;
    @(negedge clk);
    sq_if.a = av;
    sq_if.start = 1'b1;
    sb.push_back(model(av));
    @(posedge clk); #1;
    sq_if.start = 1'b0;
    n = 0; lat = -1; dn = -1; bcnt = 0;
    while (n < 40 && lat < 0) begin
      if (sq_if.busy) bcnt++;
      if (repulse && n == 5) begin
        sq_if.a = rp_a;
        sq_if.start = 1'b1;
      end
      if (n == 6) sq_if.start = 1'b0;
      @(negedge clk);
      if (sq_if.done) dn = n;
      @(posedge clk); #1;
      n++;
      if (sq_if.valid) lat = n;
    end
    check_val("latency", lat, 14);
    check_val("done_cycle", dn, 13);
    check_val("busy_cycles", bcnt, 14);
    @(negedge clk);
    check_val("busy_after", int'(sq_if.busy), 0);
  endtask

  task automatic wait_done(output int at_cycle);
    int k;
    at_cycle = -1;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sq_if.done) begin
        at_cycle = cycle;
        break;
      end
    end
    if (at_cycle < 0) check_val("done_timeout", 0, 1);
  endtask

  initial begin
    int prev_done, cur_done;
    logic [15:0] rv;

    rst = 1'b1;
    sq_if.start = 1'b0;
    sq_if.a = '0;
    #12;
    check_val("rst_busy", int'(sq_if.busy), 0);
    check_val("rst_valid", int'(sq_if.valid), 0);
    check_val("rst_neg", int'(sq_if.neg), 0);
    check_val("rst_done", int'(sq_if.done), 0);
    check_val("rst_val", int'(sq_if.val), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed values
    run_one(16'h0400, 0, 16'h0);
    run_one(16'h0200, 0, 16'h0);
    run_one(16'h0040, 0, 16'h0);
    run_one(16'h0001, 0, 16'h0);
    run_one(16'h7FFF, 0, 16'h0);
    run_one(16'h0000, 0, 16'h0);
    check_val("zero_val", int'(sq_if.val), 0);
    run_one(16'h0400, 1, 16'h0040);   // re-pulse ignored, result stays 2.0
    check_val("repulse_val", int'(sq_if.val), 16'h0200);

    // Negative radicand rejection
    @(negedge clk);
    sq_if.a = 16'hFF00;
    sq_if.start = 1'b1;
    @(posedge clk); #1;
    sq_if.start = 1'b0;
    check_val("neg_flag", int'(sq_if.neg), 1);
    check_val("neg_valid", int'(sq_if.valid), 0);
    check_val("neg_busy", int'(sq_if.busy), 0);
    check_val("neg_val_held", int'(sq_if.val), 16'h0200);
    @(posedge clk); #1;
    check_val("neg_clears", int'(sq_if.neg), 0);
    check_val("neg_no_busy", int'(sq_if.busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("neg_val_final", int'(sq_if.val), 16'h0200);

    // Reset mid-CALC discards the computation
    @(negedge clk);
    sq_if.a = 16'h7FFF;
    sq_if.start = 1'b1;
    @(posedge clk); #1;
    sq_if.start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    check_val("midrst_busy", int'(sq_if.busy), 0);
    check_val("midrst_valid", int'(sq_if.valid), 0);
    check_val("midrst_neg", int'(sq_if.neg), 0);
    check_val("midrst_done", int'(sq_if.done), 0);
    check_val("midrst_val", int'(sq_if.val), 0);
    @(negedge clk);
    rst = 1'b0;
    run_one(16'h0400, 0, 16'h0);

    // Back-to-back random operands with start held high
    @(negedge clk);
    rv = 16'($urandom_range(0, 32767));
    sq_if.a = rv;
    sq_if.start = 1'b1;
    sb.push_back(model(rv));
    prev_done = -1;
    for (int i = 0; i < 20; i++) begin
      wait_done(cur_done);
      if (cur_done < 0) break;
      if (prev_done >= 0) check_val("b2b_spacing", cur_done - prev_done, 15);
      prev_done = cur_done;
      if (i < 19) begin
        rv = 16'($urandom_range(0, 32767));
        sq_if.a = rv;
        sb.push_back(model(rv));
      end else begin
        sq_if.start = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
    check_val("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
